// File: rtl/axis_pack_32to64.sv
// axis_pack_32to64
//   Packs a stream of 32-bit AXI-Stream elements into 64-bit beats for the
//   L2-norm core. Consecutive element pairs share a beat (first element in
//   lane 0 = bits [31:0], second in lane 1 = bits [63:32]). Packet boundaries
//   are preserved: an odd-length packet ends in a zero-padded half beat with
//   tkeep = 0x0F. Beats carrying tlast are counted for debug.
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous active-low reset
//   io_in_*        32-bit element input (tdata/tvalid/tready/tlast/tuser)
//   io_out_*       64-bit beat output (tdata/tvalid/tready/tlast/tkeep/tuser)
//   io_pkt_count   number of tlast beats accepted downstream, wraps mod 2^CNT_W
module axis_pack_32to64 #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      io_in_tdata,
    input  logic             io_in_tvalid,
    output logic             io_in_tready,
    input  logic             io_in_tlast,
    input  logic             io_in_tuser,
    output logic [63:0]      io_out_tdata,
    output logic             io_out_tvalid,
    input  logic             io_out_tready,
    output logic             io_out_tlast,
    output logic [7:0]       io_out_tkeep,
    output logic             io_out_tuser,
    output logic [CNT_W-1:0] io_pkt_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] lane0;
    logic [31:0] lane0_next;
    logic        lane0_user;
    logic        lane0_user_next;

    logic        out_free;
    logic        in_fire;
    logic        out_fire;

    logic        load;
    logic [63:0] beat_data;
    logic [7:0]  beat_keep;
    logic        beat_last;
    logic        beat_user;

    // Single output register stage: room exists when it is empty or draining.
    assign out_free = !io_out_tvalid || io_out_tready;

    // Ready is held low while reset is asserted, even though the emptied
    // output register would otherwise report free space.
    assign io_in_tready = reset && out_free;

    assign in_fire  = io_in_tvalid && io_in_tready;
    assign out_fire = io_out_tvalid && io_out_tready;

    // Next state, parked lane-0 element and candidate output beat.
    always_comb begin
        state_next      = state;
        lane0_next      = lane0;
        lane0_user_next = lane0_user;
        load            = 1'b0;
        beat_data       = '0;
        beat_keep       = '0;
        beat_last       = 1'b0;
        beat_user       = 1'b0;

        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    if (io_in_tlast) begin
                        // Single trailing element: emit a padded half beat.
                        load      = 1'b1;
                        beat_data = {32'h0, io_in_tdata};
                        beat_keep = 8'h0F;
                        beat_last = 1'b1;
                        beat_user = io_in_tuser;
                    end else begin
                        lane0_next      = io_in_tdata;
                        lane0_user_next = io_in_tuser;
                        state_next      = HALF;
                    end
                end
            end
            HALF: begin
                if (in_fire) begin
                    // Lane-1 tuser is dropped; the beat carries lane-0 tuser.
                    load       = 1'b1;
                    beat_data  = {io_in_tdata, lane0};
                    beat_keep  = 8'hFF;
                    beat_last  = io_in_tlast;
                    beat_user  = lane0_user;
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            lane0      <= '0;
            lane0_user <= 1'b0;
        end else begin
            state      <= state_next;
            lane0      <= lane0_next;
            lane0_user <= lane0_user_next;
        end
    end

    // A new beat only loads when out_free, so a simultaneous drain and load
    // keeps valid high with no bubble, and a stalled beat is never touched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_tvalid <= 1'b0;
            io_out_tdata  <= '0;
            io_out_tkeep  <= '0;
            io_out_tlast  <= 1'b0;
            io_out_tuser  <= 1'b0;
        end else if (load) begin
            io_out_tvalid <= 1'b1;
            io_out_tdata  <= beat_data;
            io_out_tkeep  <= beat_keep;
            io_out_tlast  <= beat_last;
            io_out_tuser  <= beat_user;
        end else if (out_fire) begin
            io_out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_pkt_count <= '0;
        end else if (out_fire && io_out_tlast) begin
            io_pkt_count <= io_pkt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_pack_32to64.sv
// tb_axis_pack_32to64
//   Scoreboard bench for axis_pack_32to64. Each packet is built as a whole
//   element list; its expected beats are derived from that list by pairing
//   indices (2k, 2k+1) and pushed to a queue before driving. A negedge
//   monitor pops and compares every accepted beat, and also checks the
//   packet counter, ready rule and stall stability.
module tb_axis_pack_32to64;

    localparam int CNT_W = 2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic             clock;
    logic             reset;
    logic [31:0]      io_in_tdata;
    logic             io_in_tvalid;
    logic             io_in_tready;
    logic             io_in_tlast;
    logic             io_in_tuser;
    logic [63:0]      io_out_tdata;
    logic             io_out_tvalid;
    logic             io_out_tready;
    logic             io_out_tlast;
    logic [7:0]       io_out_tkeep;
    logic             io_out_tuser;
    logic [CNT_W-1:0] io_pkt_count;

    axis_pack_32to64 #(.CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_tdata   (io_in_tdata),
        .io_in_tvalid  (io_in_tvalid),
        .io_in_tready  (io_in_tready),
        .io_in_tlast   (io_in_tlast),
        .io_in_tuser   (io_in_tuser),
        .io_out_tdata  (io_out_tdata),
        .io_out_tvalid (io_out_tvalid),
        .io_out_tready (io_out_tready),
        .io_out_tlast  (io_out_tlast),
        .io_out_tkeep  (io_out_tkeep),
        .io_out_tuser  (io_out_tuser),
        .io_pkt_count  (io_pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int               checks = 0;
    int               errors = 0;
    beat_t            exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic [31:0]      pd[$];
    logic             pu[$];
    int               ready_mode;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready driver, updated just after each rising edge.
    initial begin
        io_out_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       io_out_tready = 1'b1;
                1:       io_out_tready = ($urandom_range(0, 3) != 0);
                default: io_out_tready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    logic        have_hold;
    beat_t       hold;
    always @(negedge clock) begin
        if (!reset) begin
            have_hold = 1'b0;
        end else begin
            check("pkt_count", 64'(io_pkt_count), 64'(exp_cnt));
            check("in_tready", 64'(io_in_tready), 64'(!io_out_tvalid || io_out_tready));
            if (have_hold) begin
                check("stall_valid", 64'(io_out_tvalid), 64'd1);
                check("stall_data", io_out_tdata, hold.data);
                check("stall_side", {53'd0, io_out_tkeep, io_out_tlast, io_out_tuser},
                      {53'd0, hold.keep, hold.last, hold.user});
            end
            have_hold = io_out_tvalid && !io_out_tready;
            hold.data = io_out_tdata;
            hold.keep = io_out_tkeep;
            hold.last = io_out_tlast;
            hold.user = io_out_tuser;
            if (io_out_tvalid && io_out_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", io_out_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", io_out_tdata, e.data);
                    check("beat_keep", 64'(io_out_tkeep), 64'(e.keep));
                    check("beat_last", 64'(io_out_tlast), 64'(e.last));
                    check("beat_user", 64'(io_out_tuser), 64'(e.user));
                end
                if (io_out_tlast) exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    task automatic wait_accept();
        int to;
        to = 0;
        @(negedge clock);
        while (!io_in_tready && to < 300) begin
            @(negedge clock);
            to++;
        end
        if (to >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        @(posedge clock);
        #1;
    endtask

    // Drives the packet in pd/pu; expected beats come from pairing the list.
    task automatic send_pkt();
        int    n;
        int    nb;
        beat_t b;
        n  = pd.size();
        nb = (n + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            if (2 * k + 1 < n) begin
                b.data = {pd[2*k+1], pd[2*k]};
                b.keep = 8'hFF;
            end else begin
                b.data = {32'h0, pd[2*k]};
                b.keep = 8'h0F;
            end
            b.last = (k == nb - 1);
            b.user = pu[2*k];
            exp_q.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            io_in_tvalid = 1'b1;
            io_in_tdata  = pd[i];
            io_in_tlast  = (i == n - 1);
            io_in_tuser  = pu[i];
            wait_accept();
            if (i == n - 1 || (i % 2) == 1)
                check("latency_valid", 64'(io_out_tvalid), 64'd1);
        end
        io_in_tvalid = 1'b0;
        io_in_tlast  = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (exp_q.size() != 0 && to < 500) begin
            @(posedge clock);
            to++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(io_out_tvalid), 64'd0);
        check("rst_in_ready", 64'(io_in_tready), 64'd0);
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] wrap_seq[5];
        wrap_seq     = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ready_mode   = 0;
        exp_cnt      = '0;
        reset        = 1'b0;
        io_in_tvalid = 1'b0;
        io_in_tdata  = '0;
        io_in_tlast  = 1'b0;
        io_in_tuser  = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("reset_valid", 64'(io_out_tvalid), 64'd0);
        check("reset_ready", 64'(io_in_tready), 64'd0);
        check("reset_count", 64'(io_pkt_count), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 4-element packet
        pd = '{32'h11, 32'h22, 32'h33, 32'h44};
        pu = '{1'b0, 1'b0, 1'b0, 1'b0};
        send_pkt();
        drain();
        check("count_after_4", 64'(io_pkt_count), 64'd1);

        // 3-element packet
        pd = '{32'hA, 32'hB, 32'hC};
        pu = '{1'b1, 1'b0, 1'b1};
        send_pkt();
        drain();

        // single element with tuser
        pd = '{32'hDEADBEEF};
        pu = '{1'b1};
        send_pkt();
        drain();

        // 8-element packet with a 5-cycle downstream stall mid-stream
        pd = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108};
        pu = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fork
            send_pkt();
            begin
                repeat (3) @(posedge clock);
                ready_mode = 2;
                repeat (5) @(posedge clock);
                ready_mode = 0;
            end
        join
        drain();

        // reset between the two elements of a pair
        io_in_tvalid = 1'b1;
        io_in_tdata  = 32'hBAD0BAD0;
        io_in_tlast  = 1'b0;
        io_in_tuser  = 1'b1;
        wait_accept();
        io_in_tvalid = 1'b0;
        do_reset();
        pd = '{32'h1, 32'h2};
        pu = '{1'b0, 1'b1};
        send_pkt();
        drain();
        check("count_after_rst", 64'(io_pkt_count), 64'd1);

        // counter wrap with CNT_W = 2
        do_reset();
        for (int p = 0; p < 5; p++) begin
            pd = '{32'h5000 + 32'(p)};
            pu = '{1'b0};
            send_pkt();
            drain();
            check("count_wrap", 64'(io_pkt_count), 64'(wrap_seq[p]));
        end

        // randomized packets under random backpressure
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 9);
            pd.delete();
            pu.delete();
            for (int i = 0; i < len; i++) begin
                pd.push_back($urandom);
                pu.push_back(1'($urandom_range(0, 1)));
            end
            send_pkt();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clock);
            #1;
        end
        ready_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pack_32to64.md
Name: axis_pack_32to64

Overview:
- Upstream neighbour of the L2-norm stage.
- Accepts a stream of 32-bit vector elements over AXI-Stream and packs consecutive element pairs into 64-bit beats, which it presents to the norm core's 64-bit input.
- Preserves packet boundaries. Odd-length packets end in a half-filled beat, zero-padded, with tkeep marking the valid lane.
- Also counts emitted packets for debug.

Parameters:
- CNT_W, 16, width of the emitted-packet counter (wraps modulo 2^CNT_W).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- io_in_tdata  in  32  input element.
- io_in_tvalid  in  1  input element valid.
- io_in_tready  out  1  block can accept an input element.
- io_in_tlast  in  1  element is the last of its packet.
- io_in_tuser  in  1  sideband marker, carried per beat.
- io_out_tdata  out  64  packed beat; lane 0 = bits [31:0], lane 1 = bits [63:32].
- io_out_tvalid  out  1  beat valid.
- io_out_tready  in  1  downstream accepts beat.
- io_out_tlast  out  1  beat is the last of its packet.
- io_out_tkeep  out  8  byte enables: 0xFF for a full beat, 0x0F for a half beat.
- io_out_tuser  out  1  tuser of the lane-0 element of the beat.
- io_pkt_count  out  CNT_W  number of tlast beats accepted downstream.

Behaviour:
- Reset (reset=0, asynchronous): all outputs and state clear to 0; io_in_tready=0 while reset is asserted. Any held lane-0 element and any pending output beat are discarded. The block resumes in EMPTY on the first clock after deassertion.
- Input fire: io_in_tvalid & io_in_tready. Output fire: io_out_tvalid & io_out_tready.
- Output is a single register stage. Define out_free = !io_out_tvalid | io_out_tready.
- io_in_tready = out_free outside reset, in every state. This is conservative and holds even when the element will only be parked.
- Lane order: the first element of a pair goes to lane 0 (bits [31:0]), the second to lane 1.
- State EMPTY (no lane-0 element held):
  - Fire with tlast=0: store the element as lane 0, latch its tuser, go to HALF. No output change.
  - Fire with tlast=1: load the output register with tdata={32'h0, element}, tkeep=0x0F, tlast=1, tuser=in tuser, valid=1. Stay in EMPTY.
- State HALF (lane 0 held):
  - Fire: load the output register with tdata={element, held}, tkeep=0xFF, tlast=in tlast, tuser=held tuser, valid=1. Go to EMPTY.
- Latency: io_out_tvalid rises on the clock edge that accepts the completing element, i.e. visible one cycle after that input fire.
- Throughput: with io_out_tready=1 continuously, one element is accepted per cycle and one beat is produced every 2 elements.
- Output stability: while io_out_tvalid=1 and io_out_tready=0, tdata, tkeep, tlast and tuser do not change.
- Output fire with no new beat loaded that cycle: io_out_tvalid goes to 0 next cycle.
- Simultaneous output fire and new beat load in the same cycle: the register takes the new beat and valid stays 1, with no bubble.
- io_pkt_count increments by 1 on each output fire with io_out_tlast=1, wrapping to 0 after 2^CNT_W-1.
- io_in_tuser on a lane-1 element is ignored.
- io_in_tvalid=0 never changes state. A held lane-0 element waits indefinitely.
- Zero-length packets cannot occur; every tlast arrives on a valid element.

Test Plan:
- 4-element packet 0x11, 0x22, 0x33, 0x44 (tlast on 0x44), tready=1 -> beats 0x00000022_00000011 (tkeep 0xFF, tlast 0) then 0x00000044_00000033 (tkeep 0xFF, tlast 1); io_pkt_count=1.
- 3-element packet 0xA, 0xB, 0xC (tlast on 0xC) -> 0x0000000B_0000000A (tlast 0) then 0x00000000_0000000C (tkeep 0x0F, tlast 1).
- Single-element packet 0xDEADBEEF with tlast, tuser=1 -> one beat 0x00000000_DEADBEEF, tkeep 0x0F, tlast 1, tuser 1, valid exactly one cycle after the input fire.
- Back-to-back 8-element packet with io_out_tready held 0 for 5 cycles mid-stream -> io_in_tready=0 while the output is valid and stalled; the held beat stays bit-stable; all 4 beats arrive in order with no loss or duplication.
- reset pulled to 0 between the 1st and 2nd element of a pair, off-clock-edge -> io_out_tvalid=0 immediately; a subsequent 2-element packet 0x1, 0x2 yields exactly 0x00000002_00000001 with no stale lane-0 data.
- CNT_W=2, 5 single-element packets -> io_pkt_count sequence 1, 2, 3, 0, 1.
